data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the CPU data-memory interface: a byte-addressed RAM behind a valid/ready
//  request/response handshake with fixed multi-cycle latency. Executes loads/stores selected by
//  funct3 (RV32I widths) for the memory stage; replaces single-cycle data RAM when stalls exist.
// PARAMETERS
//  DATA_WIDTH  32  data bus width; only 32 supported
//  ADDR_WIDTH  17  byte-address bits decoded; RAM = 2**ADDR_WIDTH bytes, upper addr bits ignored
//  LATENCY     2   cycles from request accept edge to rsp_valid high; legal range 1..15
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   synchronous reset, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept (IDLE only)
//  req_addr    in   32  byte address
//  req_we      in   1   1 = store, 0 = load
//  req_wdata   in   32  store data, LSB-aligned (SB uses [7:0], SH uses [15:0])
//  req_funct3  in   3   access width/sign, RV32I encoding
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   requester takes response
//  rsp_rdata   out  32  load result, extended; 0 for stores
//  rsp_err     out  1   access faulted (MISALIGN_TRAP_EN only, else tied 0)
// BEHAVIOUR
//  Reset: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0; req_ready=0
//   while rst high. RAM contents NOT cleared.
//  FSM IDLE -> WAIT -> RESP -> IDLE. req_ready = (state==IDLE) && !rst.
//  IDLE: on req_valid&&req_ready latch addr/we/wdata/funct3, cnt<=LATENCY-1; go WAIT
//   (LATENCY=1: go straight to RESP at next edge performing access).
//  WAIT: cnt decrements each edge; edge where cnt==0 performs access, loads rsp_*, enters RESP.
//   => accept at edge N, rsp_valid high after edge N+LATENCY.
//  Access: little-endian; byte i of word at addr+i, addr wraps modulo 2**ADDR_WIDTH.
//   Store 000 SB / 001 SH / 010 SW: write 1/2/4 bytes at access edge only.
//   Load 000 LB / 001 LH sign-extend; 100 LBU / 101 LHU zero-extend; 010 LW.
//   Other funct3 (011,110,111): no RAM write, rdata=0.
//  RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready; then IDLE,
//   rsp_valid=0. No accept in same cycle as response handshake (req_ready=0 in RESP).
//  Store response rdata=0. Back-to-back throughput: one access per LATENCY+2 cycles min.
//  rsp_ready held low: stay in RESP indefinitely, req ignored.
//  Reset mid-operation: pending store not yet at access edge is dropped; store already
//   committed stays; pending response discarded.
//  Inputs other than req_valid are don't-care outside the accept cycle.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]!=0, LW/SW with addr[1:0]!=0, or invalid
//   funct3 -> no RAM write, rsp_rdata=0, rsp_err=1 in response; legal accesses rsp_err=0.
//  Not defined: misaligned accesses performed byte-exact at addr..addr+n-1 (wrapping);
//   invalid funct3 as above but rsp_err tied 0; no err logic synthesised.
// TESTING
//  1 Reset: rst 2 cycles -> rsp_valid=0, rsp_err=0, req_ready=0 in rst, =1 first cycle after.
//  2 SW 0xDEADBEEF @0x100, LW @0x100, LATENCY=2, rsp_ready=1 -> rsp_valid 2 cycles after
//    accept, load rdata=0xDEADBEEF, store rdata=0.
//  3 After 2: LB @0x100 -> 0xFFFFFFEF; LBU @0x103 -> 0x000000DE; LH @0x102 -> 0xFFFFDEAD;
//    SB 0x12 @0x101 then LW @0x100 -> 0xDEAD12EF.
//  4 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0,
//    new req_valid not accepted; accept only after handshake + return to IDLE.
//  5 Reset mid-op: SW 0x11111111 @0x40 accepted, rst at next edge (LATENCY=3), then LW @0x40
//    -> prior contents (unchanged), no stale response after reset.
//  6 LW @0x102: with MISALIGN_TRAP_EN -> rsp_err=1, rdata=0; without -> rsp_err=0,
//    rdata = bytes 0x105..0x102 little-endian; funct3=011 -> rdata=0, no write.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the memory-stage requester and the data-memory responder.
interface data_mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [31:0]           req_addr;
    logic                  req_we;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [2:0]            req_funct3;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-addressed data RAM behind a valid/ready handshake with fixed access latency.
// Optional MISALIGN_TRAP_EN: faults misaligned/invalid accesses through rsp_err instead of performing them.
module data_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus
);
    localparam int         ROW_W    = ADDR_WIDTH - 2;
    localparam int         DEPTH    = 2 ** ROW_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Sign/zero extension of the little-endian bytes gathered for a load.
    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] res;
        case (f3)
            3'b000:  res = {{24{raw[7]}}, raw[7:0]};
            3'b001:  res = {{16{raw[15]}}, raw[15:0]};
            3'b010:  res = raw;
            3'b100:  res = {24'd0, raw[7:0]};
            3'b101:  res = {16'd0, raw[15:0]};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    logic [1:0]            state_r;
    logic [3:0]            cnt_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  we_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [2:0]            funct3_r;
    logic                  rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;

    // Four byte lanes; lane b holds every byte whose address has [1:0] == b.
    logic [7:0]            bank_r [4][DEPTH];

    logic                  access_s;
    logic [2:0]            nbytes_s;
    logic                  f3_valid_s;
    logic                  fault_s;
    logic                  do_write_s;
    logic [1:0]            off_s     [4];
    logic [ADDR_WIDTH-1:0] baddr_s   [4];
    logic [3:0]            wr_en_s;
    logic [7:0]            wbyte_s   [4];
    logic [7:0]            bank_rd_s [4];
    logic [31:0]           raw_s;
    logic [31:0]           load_s;
    logic                  unused_addr_s;

    assign unused_addr_s = ^bus.req_addr[31:ADDR_WIDTH];
    assign access_s      = (state_r == ST_WAIT) && (cnt_r == 4'd0);
    assign bus.req_ready = (state_r == ST_IDLE) && !rst;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;

    // Access width and legality of the latched funct3; stores only accept SB/SH/SW.
    always_comb begin
        nbytes_s   = 3'd0;
        f3_valid_s = 1'b0;
        case (funct3_r)
            3'b000: begin nbytes_s = 3'd1; f3_valid_s = 1'b1;  end
            3'b001: begin nbytes_s = 3'd2; f3_valid_s = 1'b1;  end
            3'b010: begin nbytes_s = 3'd4; f3_valid_s = 1'b1;  end
            3'b100: begin nbytes_s = 3'd1; f3_valid_s = !we_r; end
            3'b101: begin nbytes_s = 3'd2; f3_valid_s = !we_r; end
            default: begin nbytes_s = 3'd0; f3_valid_s = 1'b0; end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic rsp_err_r;
    logic misalign_s;

    // Halfwords need even addresses, words need 4-byte alignment.
    always_comb begin
        misalign_s = 1'b0;
        if (nbytes_s == 3'd2) begin
            misalign_s = addr_r[0];
        end else if (nbytes_s == 3'd4) begin
            misalign_s = (addr_r[1:0] != 2'b00);
        end else begin
            misalign_s = 1'b0;
        end
    end

    assign fault_s     = misalign_s || !f3_valid_s;
    assign bus.rsp_err = rsp_err_r;
`else
    assign fault_s     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    assign do_write_s = we_r && f3_valid_s && !fault_s;

    // Map each lane to the access byte offset it serves; addresses wrap within the RAM.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            off_s[b]     = 2'(b) - addr_r[1:0];
            baddr_s[b]   = addr_r + ADDR_WIDTH'(off_s[b]);
            wr_en_s[b]   = access_s && !rst && do_write_s && ({1'b0, off_s[b]} < nbytes_s);
            wbyte_s[b]   = wdata_r[8*off_s[b] +: 8];
            bank_rd_s[b] = bank_r[b][baddr_s[b][ADDR_WIDTH-1:2]];
        end
    end

    // Reassemble lane read data into access byte order, then extend.
    always_comb begin
        raw_s = 32'd0;
        for (int i = 0; i < 4; i++) begin
            raw_s[8*i +: 8] = bank_rd_s[2'(addr_r[1:0] + 2'(i))];
        end
        if (fault_s || we_r) begin
            load_s = 32'd0;
        end else begin
            load_s = extend_load(funct3_r, raw_s);
        end
    end

    // RAM lane writes at the access edge; contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en_s[b]) begin
                bank_r[b][baddr_s[b][ADDR_WIDTH-1:2]] <= wbyte_s[b];
            end
        end
    end

    // Handshake FSM: accept in IDLE, count down in WAIT, hold the response in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            we_r        <= 1'b0;
            wdata_r     <= {DATA_WIDTH{1'b0}};
            funct3_r    <= 3'd0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
`ifdef MISALIGN_TRAP_EN
            rsp_err_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        addr_r   <= bus.req_addr[ADDR_WIDTH-1:0];
                        we_r     <= bus.req_we;
                        wdata_r  <= bus.req_wdata;
                        funct3_r <= bus.req_funct3;
                        cnt_r    <= CNT_INIT;
                        state_r  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= load_s;
`ifdef MISALIGN_TRAP_EN
                        rsp_err_r   <= fault_s;
`endif
                        state_r     <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
